victim_cache_ctrl: RTL and testbench
====================================

Name: victim_cache_ctrl

Overview:
- Controller and storage for the 8-entry fully-associative exclusive victim cache.
- Accepts lines evicted from L1 and answers L1-miss lookups; a hit removes the line (swap back to L1).
- Drives the existing 8-way LRU tracker: sends `lru_update` / `add_cache` pulses and consumes its one-hot `lru_number`.
- When full, replaces the LRU entry and writes dirty victims back to L2 through a valid/ready port.

Parameters:
- TAG_W, 26, line tag width.
- DATA_W, 128, line data width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ins_valid  in  1  L1 eviction insert request.
- ins_ready  out  1  insert accepted when `ins_valid & ins_ready` on a rising edge.
- ins_tag  in  TAG_W  inserted line tag.
- ins_data  in  DATA_W  inserted line data.
- ins_dirty  in  1  inserted line is dirty.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted when `lk_valid & lk_ready`.
- lk_tag  in  TAG_W  lookup tag.
- lk_resp_valid  out  1  one-cycle response strobe.
- lk_hit  out  1  response hit flag.
- lk_data  out  DATA_W  hit data (0 on miss).
- lk_dirty  out  1  hit line dirty bit.
- wb_valid  out  1  writeback request to L2.
- wb_ready  in  1  L2 accepts writeback.
- wb_tag  out  TAG_W  writeback tag.
- wb_data  out  DATA_W  writeback data.
- lru_number  in  8  one-hot LRU entry from the tracker.
- lru_update  out  8  one-hot "make newest" pulse to the tracker.
- add_cache  out  1  pulse: the current LRU entry becomes newest.

Behaviour:
- Reset (async, `reset_n`=0):
  - all valid bits cleared; state IDLE.
  - all outputs 0 except `lk_ready`=`ins_ready`=1 once `reset_n` deasserts.
- State machine: IDLE, WB, FILL.
  - `lk_ready` = (state==IDLE).
  - `ins_ready` = (state==IDLE) & ~`lk_valid`. Lookup has priority over a simultaneous insert.
- Lookup accepted at edge T:
  - tag compared against all valid entries at T.
  - `lk_resp_valid`=1 for exactly cycle T+1, with `lk_hit`/`lk_data`/`lk_dirty` registered.
  - On hit, that entry's valid bit clears at edge T.
  - No LRU pulse is sent on a lookup.
- Insert accepted at edge T; the target is latched at T:
  - (a) If `ins_tag` is already valid: that entry is the target.
  - (b) Otherwise, the lowest-index invalid entry is the target.
  - (c) Otherwise (full), the victim = `lru_number` sampled at T.
- Next state after an accepted insert:
  - Case (c) with the victim dirty → WB. Otherwise → FILL.
- WB state:
  - `wb_valid`=1 with the victim's tag/data, held stable until `wb_ready`.
  - On handshake → FILL.
  - No timeout; `wb_ready` may stall indefinitely.
- FILL state (exactly 1 cycle):
  - entry written, valid set, dirty = `ins_dirty`, at the end of the cycle.
  - Cases (a)/(b): `lru_update` = one-hot(target), `add_cache`=0.
  - Case (c): `add_cache`=1, `lru_update`=0.
  - Returns to IDLE.
- LRU pulses:
  - `lru_update` and `add_cache` are never asserted together, and each is high for a single cycle.
- Timing:
  - Insert latency: 2 cycles clean (accept, FILL); 3+ cycles with a dirty victim.
  - Insert data is registered at accept, so `ins_*` may change after the handshake.
- Protocol check: `lru_number` is assumed one-hot by contract. A non-one-hot value in case (c) selects the lowest set bit; all-zero selects entry 7.
- Reset mid-WB or mid-FILL: everything is dropped immediately (`wb_valid`→0); the tracker is reset by the same system reset.

Optional Feature:
- Macro: VC_STATS_EN.
- When defined:
  - adds 32-bit output counters `stat_hits`, `stat_misses`, `stat_wbs`.
  - they increment on a hit response, a miss response, and a `wb` handshake respectively.
  - counters saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: no counters, no ports; behaviour otherwise identical.

Decomposition:
- Package `vc_pkg`: `VC_ENTRIES`=8, state enum {IDLE, WB, FILL}, and a `vc_entry_t` struct {valid, dirty, tag, data}.
- One sub-module, `vc_tag_match`:
  - combinational, parallel compare of 8 tags against a tag.
  - outputs a one-hot hit vector and the lowest-invalid one-hot.
  - reused for lookup and insert.

Test Plan:
- Reset, then insert tags 0x10..0x17 clean → `lru_update` pulses 0x01,0x02,…,0x80 in successive FILL cycles; `add_cache` never set.
- With the cache full and tracker `lru_number`=0x01, insert clean tag 0x20 → `add_cache` 1-cycle pulse, no `wb_valid`; lookup 0x10 then misses and lookup 0x20 hits.
- Entry 3 dirty, `lru_number`=0x08, insert 0x30 with `wb_ready` low for 4 cycles → `wb_valid` held 4+ cycles with `wb_tag`=entry 3's tag, then FILL and `add_cache` pulse.
- Lookup 0x15 (present, dirty) → `lk_resp_valid` at T+1 with `lk_hit`=1 and `lk_dirty`=1; a repeat lookup of 0x15 misses. A following insert of 0x40 fills entry 5 with `lru_update`=0x20.
- Assert `lk_valid` and `ins_valid` in the same cycle → lookup is accepted, `ins_ready`=0 that cycle, and the insert is accepted the next IDLE cycle.
- Pull `reset_n` low while in WB → `wb_valid` drops without a clock edge, all lookups miss afterwards, `stat_*`=0 (VC_STATS_EN).

Source files
------------

// File: rtl/vc_pkg.sv
// Shared types and constants for the 8-entry exclusive victim cache.
package vc_pkg;
  localparam int VC_ENTRIES = 8;
  localparam int VC_IDX_W   = 3;
  localparam int VC_TAG_W   = 26;
  localparam int VC_DATA_W  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } vc_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_DATA_W-1:0] data;
  } vc_entry_t;

  // Index of the lowest set bit; an empty vector maps to the last entry.
  function automatic logic [VC_IDX_W-1:0] vc_lowest_idx(input logic [VC_ENTRIES-1:0] vec);
    logic [VC_IDX_W-1:0] idx;
    idx = VC_IDX_W'(VC_ENTRIES - 1);
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = VC_IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/victim_cache_ctrl_if.sv
// Insert / lookup / writeback / LRU-tracker signal bundle of the victim cache.
interface victim_cache_ctrl_if
  import vc_pkg::*;
#(
  parameter int TAG_W  = VC_TAG_W,
  parameter int DATA_W = VC_DATA_W
);
  logic                  ins_valid;
  logic                  ins_ready;
  logic [TAG_W-1:0]      ins_tag;
  logic [DATA_W-1:0]     ins_data;
  logic                  ins_dirty;
  logic                  lk_valid;
  logic                  lk_ready;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_resp_valid;
  logic                  lk_hit;
  logic [DATA_W-1:0]     lk_data;
  logic                  lk_dirty;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [TAG_W-1:0]      wb_tag;
  logic [DATA_W-1:0]     wb_data;
  logic [VC_ENTRIES-1:0] lru_number;
  logic [VC_ENTRIES-1:0] lru_update;
  logic                  add_cache;

  modport slave (
    input  ins_valid, ins_tag, ins_data, ins_dirty, lk_valid, lk_tag, wb_ready, lru_number,
    output ins_ready, lk_ready, lk_resp_valid, lk_hit, lk_data, lk_dirty,
           wb_valid, wb_tag, wb_data, lru_update, add_cache
  );

  modport master (
    output ins_valid, ins_tag, ins_data, ins_dirty, lk_valid, lk_tag, wb_ready, lru_number,
    input  ins_ready, lk_ready, lk_resp_valid, lk_hit, lk_data, lk_dirty,
           wb_valid, wb_tag, wb_data, lru_update, add_cache
  );
endinterface

// File: rtl/vc_tag_match.sv
// Parallel tag compare over all entries plus lowest-free-entry selection.
module vc_tag_match
  import vc_pkg::*;
#(
  parameter int TAG_W = VC_TAG_W
) (
  input  logic [VC_ENTRIES-1:0]            valid,
  input  logic [VC_ENTRIES-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]                 tag,
  output logic [VC_ENTRIES-1:0]            hit_oh,
  output logic [VC_ENTRIES-1:0]            free_oh
);
  logic [VC_ENTRIES-1:0] invalid;

  for (genvar gi = 0; gi < VC_ENTRIES; gi++) begin : g_cmp
    assign hit_oh[gi] = valid[gi] && (tags[gi] == tag);
  end

  // x & -x isolates the lowest invalid entry
  assign invalid = ~valid;
  assign free_oh = invalid & (~invalid + VC_ENTRIES'(1));
endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: lookup/insert FSM, entry storage, LRU pulses, L2 writeback.
// Optional statistics counters are built when VC_STATS_EN is defined.
module victim_cache_ctrl
  import vc_pkg::*;
#(
  parameter int TAG_W  = VC_TAG_W,
  parameter int DATA_W = VC_DATA_W
) (
  input logic                clk,
  input logic                reset_n,
  victim_cache_ctrl_if.slave bus
`ifdef VC_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
  output logic [31:0]        stat_wbs
`endif
);
  vc_state_e             state_q, state_d;
  vc_entry_t             mem_q [VC_ENTRIES];
  vc_entry_t             mem_d [VC_ENTRIES];
  logic [VC_IDX_W-1:0]   tgt_q, tgt_d;
  logic                  repl_q, repl_d;
  logic [TAG_W-1:0]      itag_q, itag_d;
  logic [DATA_W-1:0]     idata_q, idata_d;
  logic                  idirty_q, idirty_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  resp_dirty_q, resp_dirty_d;

  logic [VC_ENTRIES-1:0]            valid_vec, hit_oh, free_oh;
  logic [VC_ENTRIES-1:0][TAG_W-1:0] tag_vec;
  logic [TAG_W-1:0]                 match_tag;
  logic [VC_IDX_W-1:0]              hit_idx, free_idx, victim_idx;

  for (genvar gi = 0; gi < VC_ENTRIES; gi++) begin : g_flat
    assign valid_vec[gi] = mem_q[gi].valid;
    assign tag_vec[gi]   = mem_q[gi].tag;
  end

  // One comparator serves both requests; lookup wins when both are present.
  assign match_tag = bus.lk_valid ? bus.lk_tag : bus.ins_tag;

  vc_tag_match #(.TAG_W(TAG_W)) u_match (
    .valid   (valid_vec),
    .tags    (tag_vec),
    .tag     (match_tag),
    .hit_oh  (hit_oh),
    .free_oh (free_oh)
  );

  assign hit_idx    = vc_lowest_idx(hit_oh);
  assign free_idx   = vc_lowest_idx(free_oh);
  assign victim_idx = vc_lowest_idx(bus.lru_number);

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    tgt_d        = tgt_q;
    repl_d       = repl_q;
    itag_d       = itag_q;
    idata_d      = idata_q;
    idirty_d     = idirty_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_data_d  = '0;
    resp_dirty_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.lk_valid) begin
          resp_valid_d = 1'b1;
          if (|hit_oh) begin
            resp_hit_d             = 1'b1;
            resp_data_d            = mem_q[hit_idx].data;
            resp_dirty_d           = mem_q[hit_idx].dirty;
            mem_d[hit_idx].valid   = 1'b0;
          end
        end else if (bus.ins_valid) begin
          itag_d   = bus.ins_tag;
          idata_d  = bus.ins_data;
          idirty_d = bus.ins_dirty;
          state_d  = FILL;
          if (|hit_oh) begin
            tgt_d  = hit_idx;
            repl_d = 1'b0;
          end else if (|free_oh) begin
            tgt_d  = free_idx;
            repl_d = 1'b0;
          end else begin
            tgt_d  = victim_idx;
            repl_d = 1'b1;
            if (mem_q[victim_idx].dirty) state_d = WB;
          end
        end
      end
      WB: begin
        if (bus.wb_ready) state_d = FILL;
      end
      FILL: begin
        mem_d[tgt_q] = '{valid: 1'b1, dirty: idirty_q, tag: itag_q, data: idata_q};
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < VC_ENTRIES; i++) mem_q[i] <= '0;
      tgt_q        <= '0;
      repl_q       <= 1'b0;
      itag_q       <= '0;
      idata_q      <= '0;
      idirty_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_dirty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      tgt_q        <= tgt_d;
      repl_q       <= repl_d;
      itag_q       <= itag_d;
      idata_q      <= idata_d;
      idirty_q     <= idirty_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      resp_dirty_q <= resp_dirty_d;
    end
  end

  assign bus.lk_ready      = (state_q == IDLE);
  assign bus.ins_ready     = (state_q == IDLE) && !bus.lk_valid;
  assign bus.lk_resp_valid = resp_valid_q;
  assign bus.lk_hit        = resp_hit_q;
  assign bus.lk_data       = resp_data_q;
  assign bus.lk_dirty      = resp_dirty_q;
  // The victim entry is untouched until FILL, so WB reads it straight from storage.
  assign bus.wb_valid      = (state_q == WB);
  assign bus.wb_tag        = (state_q == WB) ? mem_q[tgt_q].tag : '0;
  assign bus.wb_data       = (state_q == WB) ? mem_q[tgt_q].data : '0;
  assign bus.add_cache     = (state_q == FILL) && repl_q;
  assign bus.lru_update    = ((state_q == FILL) && !repl_q) ? (VC_ENTRIES'(1) << tgt_q) : '0;

`ifdef VC_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (state_q == IDLE && bus.lk_valid) begin
      if (|hit_oh) hits_d   = sat_inc(hits_q);
      else         misses_d = sat_inc(misses_q);
    end
    if (state_q == WB && bus.wb_ready) wbs_d = sat_inc(wbs_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbs    = wbs_q;
`endif
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl: directed scenarios, random traffic, async reset.
module tb_victim_cache_ctrl;
  import vc_pkg::*;
  localparam int TW = 26;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  victim_cache_ctrl_if #(.TAG_W(TW), .DATA_W(DW)) bus ();
`ifdef VC_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

  victim_cache_ctrl #(.TAG_W(TW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef VC_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbs    (stat_wbs)
`endif
  );

  // Behavioural model of the cache contents
  bit            m_valid [8];
  bit            m_dirty [8];
  logic [TW-1:0] m_tag   [8];
  logic [DW-1:0] m_data  [8];
  int            s_hits, s_misses, s_wbs;

  // Expected outputs for the current cycle
  bit            chk_en;
  bit            exp_lk_ready, exp_ins_ready, exp_resp, exp_hit, exp_dirty;
  logic [DW-1:0] exp_data, exp_wb_data;
  bit            exp_wb_valid, exp_add_cache;
  logic [TW-1:0] exp_wb_tag;
  logic [7:0]    exp_lru_update;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lk_ready", bus.lk_ready, exp_lk_ready);
      chk("ins_ready", bus.ins_ready, exp_ins_ready);
      chk("lk_resp_valid", bus.lk_resp_valid, exp_resp);
      if (exp_resp) begin
        chk("lk_hit", bus.lk_hit, exp_hit);
        chk("lk_data", bus.lk_data, exp_data);
        chk("lk_dirty", bus.lk_dirty, exp_dirty);
      end
      chk("wb_valid", bus.wb_valid, exp_wb_valid);
      if (exp_wb_valid) begin
        chk("wb_tag", bus.wb_tag, exp_wb_tag);
        chk("wb_data", bus.wb_data, exp_wb_data);
      end
      chk("lru_update", bus.lru_update, exp_lru_update);
      chk("add_cache", bus.add_cache, exp_add_cache);
`ifdef VC_STATS_EN
      chk("stat_hits", stat_hits, s_hits);
      chk("stat_misses", stat_misses, s_misses);
      chk("stat_wbs", stat_wbs, s_wbs);
`endif
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_lk_ready   = 1'b1;
    exp_ins_ready  = !bus.lk_valid;
    exp_resp       = 1'b0;
    exp_hit        = 1'b0;
    exp_data       = '0;
    exp_dirty      = 1'b0;
    exp_wb_valid   = 1'b0;
    exp_wb_tag     = '0;
    exp_wb_data    = '0;
    exp_lru_update = '0;
    exp_add_cache  = 1'b0;
  endtask

  task automatic set_busy();
    set_idle();
    exp_lk_ready  = 1'b0;
    exp_ins_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    s_hits = 0;
    s_misses = 0;
    s_wbs = 0;
  endtask

  // Placement rules: matching tag, else lowest free slot, else LRU victim
  task automatic model_decide(input logic [TW-1:0] tag, input logic [7:0] lru,
                              output int tgt, output bit repl);
    tgt = -1;
    repl = 1'b0;
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tag) tgt = i;
    if (tgt < 0) for (int i = 7; i >= 0; i--) if (!m_valid[i]) tgt = i;
    if (tgt < 0) begin
      repl = 1'b1;
      tgt = 7;
      for (int i = 7; i >= 0; i--) if (lru[i]) tgt = i;
    end
  endtask

  // Called just after the insert-accept edge
  task automatic ins_finish(input int tgt, input bit repl, input logic [TW-1:0] tag,
                            input logic [DW-1:0] data, input bit dirty, input int stall,
                            input int lit_lru, input int lit_wbtag);
    bus.ins_valid  = 1'b0;
    bus.ins_tag    = TW'($urandom());
    bus.ins_data   = rnd_data();
    bus.ins_dirty  = 1'($urandom_range(0, 1));
    bus.lru_number = 8'($urandom_range(0, 255));
    if (repl && m_dirty[tgt]) begin
      for (int k = 0; k <= stall; k++) begin
        bus.wb_ready = (k == stall);
        set_busy();
        exp_wb_valid = 1'b1;
        exp_wb_tag   = m_tag[tgt];
        exp_wb_data  = m_data[tgt];
        if (k == 0 && lit_wbtag >= 0) begin
          @(negedge clk);
          chk("wb_tag_literal", bus.wb_tag, 128'(lit_wbtag));
        end
        step();
      end
      bus.wb_ready = 1'b0;
      s_wbs++;
    end
    set_busy();
    if (repl) exp_add_cache = 1'b1;
    else      exp_lru_update = 8'b1 << tgt;
    if (lit_lru >= 0) begin
      @(negedge clk);
      chk("lru_update_literal", bus.lru_update, 128'(lit_lru));
    end
    step();
    m_valid[tgt] = 1'b1;
    m_dirty[tgt] = dirty;
    m_tag[tgt]   = tag;
    m_data[tgt]  = data;
    set_idle();
  endtask

  task automatic do_insert(input logic [TW-1:0] tag, input logic [DW-1:0] data, input bit dirty,
                           input logic [7:0] lru, input int stall, input int lit_lru,
                           input int lit_wbtag);
    int tgt;
    bit repl;
    bus.ins_valid  = 1'b1;
    bus.ins_tag    = tag;
    bus.ins_data   = data;
    bus.ins_dirty  = dirty;
    bus.lru_number = lru;
    set_idle();
    model_decide(tag, lru, tgt, repl);
    step();
    ins_finish(tgt, repl, tag, data, dirty, stall, lit_lru, lit_wbtag);
  endtask

  task automatic do_lookup(input logic [TW-1:0] tag, input int lit_hit, input int lit_dirty,
                           input bit with_ins, input logic [TW-1:0] itag,
                           input logic [DW-1:0] idata, input bit idirty, input logic [7:0] lru,
                           input int lit_lru);
    int hit_i;
    int tgt;
    bit repl;
    bus.lk_valid = 1'b1;
    bus.lk_tag   = tag;
    if (with_ins) begin
      bus.ins_valid  = 1'b1;
      bus.ins_tag    = itag;
      bus.ins_data   = idata;
      bus.ins_dirty  = idirty;
      bus.lru_number = lru;
    end
    set_idle();
    if (with_ins) begin
      @(negedge clk);
      chk("ins_ready_blocked", bus.ins_ready, 0);
    end
    step();
    bus.lk_valid = 1'b0;
    bus.lk_tag   = TW'($urandom());
    hit_i = -1;
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tag) hit_i = i;
    set_idle();
    exp_resp = 1'b1;
    if (hit_i >= 0) begin
      exp_hit   = 1'b1;
      exp_data  = m_data[hit_i];
      exp_dirty = m_dirty[hit_i];
      m_valid[hit_i] = 1'b0;
      s_hits++;
    end else begin
      s_misses++;
    end
    if (lit_hit >= 0 || lit_dirty >= 0) begin
      @(negedge clk);
      if (lit_hit >= 0)   chk("lk_hit_literal", bus.lk_hit, 128'(lit_hit));
      if (lit_dirty >= 0) chk("lk_dirty_literal", bus.lk_dirty, 128'(lit_dirty));
    end
    if (with_ins) begin
      model_decide(itag, lru, tgt, repl);
      step();
      ins_finish(tgt, repl, itag, idata, idirty, 0, lit_lru, -1);
    end else begin
      step();
      set_idle();
    end
  endtask

  task automatic lookup(input logic [TW-1:0] tag, input int lit_hit, input int lit_dirty);
    do_lookup(tag, lit_hit, lit_dirty, 1'b0, '0, '0, 1'b0, 8'h01, -1);
  endtask

  initial begin
    int tgt;
    bit repl;
    logic [7:0] lru;
    bus.ins_valid  = 1'b0;
    bus.ins_tag    = '0;
    bus.ins_data   = '0;
    bus.ins_dirty  = 1'b0;
    bus.lk_valid   = 1'b0;
    bus.lk_tag     = '0;
    bus.wb_ready   = 1'b0;
    bus.lru_number = 8'h01;
    chk_en = 1'b0;
    model_reset();
    set_idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    set_idle();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_lk_ready", bus.lk_ready, 1);
    chk("rst_ins_ready", bus.ins_ready, 1);
    chk("rst_resp_valid", bus.lk_resp_valid, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_lru_update", bus.lru_update, 0);
    step();

    // Fill with clean lines: one LRU pulse per slot
    for (int i = 0; i < 8; i++) do_insert(TW'(32'h10 + i), rnd_data(), 1'b0, 8'h01, 0, 1 << i, -1);
    // Full cache, clean victim at entry 0
    do_insert(TW'(32'h20), rnd_data(), 1'b0, 8'h01, 0, 0, -1);
    lookup(TW'(32'h10), 0, -1);
    // Make entries 3 and 5 dirty in place
    do_insert(TW'(32'h13), rnd_data(), 1'b1, 8'h01, 0, 8'h08, -1);
    do_insert(TW'(32'h15), rnd_data(), 1'b1, 8'h01, 0, 8'h20, -1);
    // Dirty victim 3 with a four-cycle writeback stall
    do_insert(TW'(32'h30), rnd_data(), 1'b0, 8'h08, 4, 0, 32'h13);
    lookup(TW'(32'h15), 1, 1);
    lookup(TW'(32'h15), 0, -1);
    do_insert(TW'(32'h40), rnd_data(), 1'b0, 8'h01, 0, 8'h20, -1);
    lookup(TW'(32'h20), 1, 0);
    // Simultaneous lookup and insert: lookup first, insert lands in freed entry 0
    do_lookup(TW'(32'h40), 1, 0, 1'b1, TW'(32'h50), rnd_data(), 1'b0, 8'h01, 8'h01);

    // Random traffic over a small tag pool
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) lru = 8'($urandom_range(0, 255));
      else                           lru = 8'b1 << $urandom_range(0, 7);
      if (op <= 3) begin
        lookup(TW'(32'h100 + $urandom_range(0, 15)), -1, -1);
      end else if (op <= 8) begin
        do_insert(TW'(32'h100 + $urandom_range(0, 15)), rnd_data(), 1'($urandom_range(0, 1)),
                  lru, $urandom_range(0, 3), -1, -1);
      end else begin
        do_lookup(TW'(32'h100 + $urandom_range(0, 15)), -1, -1, 1'b1,
                  TW'(32'h100 + $urandom_range(0, 15)), rnd_data(), 1'($urandom_range(0, 1)),
                  lru, -1);
      end
    end

    // Fill with fresh dirty lines, then reset in the middle of a writeback
    for (int i = 0; i < 8; i++)
      do_insert(TW'(32'h300 + i), rnd_data(), 1'b1, 8'b1 << $urandom_range(0, 7), 0, -1, -1);
    model_decide(TW'(32'h307), 8'h01, tgt, repl);
    bus.ins_valid  = 1'b1;
    bus.ins_tag    = TW'(32'h3FF);
    bus.ins_data   = rnd_data();
    bus.ins_dirty  = 1'b0;
    bus.lru_number = 8'b1 << tgt;
    set_idle();
    step();
    bus.ins_valid = 1'b0;
    bus.wb_ready  = 1'b0;
    set_busy();
    exp_wb_valid = 1'b1;
    exp_wb_tag   = m_tag[tgt];
    exp_wb_data  = m_data[tgt];
    @(negedge clk);
    chk("wb_tag_before_reset", bus.wb_tag, 128'(32'h307));
    @(posedge clk);
    #3;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("wb_valid_async_drop", bus.wb_valid, 0);
    chk("add_cache_in_reset", bus.add_cache, 0);
`ifdef VC_STATS_EN
    chk("stat_hits_in_reset", stat_hits, 0);
    chk("stat_wbs_in_reset", stat_wbs, 0);
`endif
    model_reset();
    #20;
    @(posedge clk);
    #1 reset_n = 1'b1;
    set_idle();
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) lookup(TW'(32'h300 + i), 0, -1);
    lookup(TW'(32'h3FF), 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
